door_round_controller: RTL
==========================

# door_round_controller

Game-round sequencer that drives the door-game screen drawer. Generates the two correct doors per round and runs the selection countdown. Moves both players on button pulses, raises `time_up` for the reveal, and deducts lives. All outputs feed the drawer's inputs directly: `correct_door_1/2`, `p1_lives`, `p2_lives`, `player_1_pos`, `player_2_pos` and `time_up`.

## Interface
- ROUND_TICKS, 10: `tick` pulses in one selection period.
- REVEAL_TICKS, 3: `tick` pulses the doors stay revealed.
- START_LIVES, 3: lives per player at game start; legal range 1..3.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable pulse, 1 Hz from an external divider.
- start  in  1  one-cycle pulse; starts a new game from IDLE or OVER.
- p1_left, p1_right  in  1 each  one-cycle debounced button pulses for player 1.
- p2_left, p2_right  in  1 each  one-cycle debounced button pulses for player 2.
- correct_door_1, correct_door_2  out  2 each  indices of the two open doors; always distinct.
- player_1_pos, player_2_pos  out  2 each  selected door per player.
- p1_lives, p2_lives  out  2 each  remaining lives.
- time_up  out  1  high during the reveal.
- seconds_left  out  4  countdown value during SELECT; 0 otherwise.
- game_over  out  1  high in OVER.
- winner  out  2  01 = P1, 10 = P2, 11 = tie, 00 = none.

## Operation
- FSM states: IDLE, SELECT, REVEAL, SCORE, CHECK, OVER.
- **IDLE**
  - Lives = START_LIVES.
  - start → SELECT.
- **Entering SELECT**
  - Latch the LFSR: door1 = lfsr[1:0], d2 = lfsr[3:2].
  - If d2 == door1, door2 = door1 + 1 (mod 4); otherwise door2 = d2.
  - Both positions cleared to 0.
  - seconds_left = ROUND_TICKS.
- **SELECT**
  - Each tick decrements seconds_left.
  - On the tick that makes seconds_left 0 → REVEAL.
  - A left pulse decrements the player's position, saturating at 0.
  - A right pulse increments it, saturating at 3.
  - Left and right in the same cycle for the same player: no change.
  - The two players update independently.
  - Button pulses are ignored in every other state.
- **REVEAL**
  - time_up = 1; positions frozen.
  - Counts REVEAL_TICKS ticks, then → SCORE.
- **SCORE** (1 cycle)
  - Each player whose position matches neither door1 nor door2 loses one life, saturating at 0.
  - Both players may lose a life in the same cycle.
- **CHECK** (1 cycle)
  - If either life count == 0 → OVER, with winner set.
  - Otherwise → SELECT (new round, doors re-latched).
- **OVER**
  - game_over = 1; doors, positions and lives held for display.
  - start → reload lives to START_LIVES, clear winner → SELECT.
- **LFSR**
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Free-runs every clk in all states, so door choice depends on player timing.
- start outside IDLE/OVER: ignored.

## Timing
- All outputs registered; each changes on the clk edge after the causing event.
  - Button pulse at edge n → position valid after edge n+1.
  - The final SELECT tick → time_up = 1 one cycle later.
- Round length: ROUND_TICKS + REVEAL_TICKS ticks + 2 clk (SCORE, CHECK).
- Lives update is visible 1 cycle after the REVEAL exit; game_over is visible 1 cycle after that.
- A tick coinciding with a button pulse on the last SELECT cycle: the move is applied, and the round still ends.
- Reset is asynchronous and may occur mid-round. Reset values:
  - state IDLE, LFSR = LFSR_SEED.
  - correct_door_1 = 0, correct_door_2 = 1.
  - positions 0.
  - lives = START_LIVES.
  - time_up 0, seconds_left 0, game_over 0, winner 00.
- Drawer inputs hold steady for a whole frame except at state edges; no frame synchronisation is required.

## Structure
- Shared package `door_game_pkg`:
  - state enum `round_state_t`.
  - `door_idx_t` (logic [1:0]).
  - winner codes WIN_NONE / WIN_P1 / WIN_P2 / WIN_TIE.
  - LFSR tap constant.
- One sub-module: `lfsr8`, with enable tied high and a seed parameter.
- Position saturation logic is instantiated twice as a function, not as a module.

## Test plan
- Reset, then start with LFSR state 8'hA5 latched (door1 = 01, d2 = 01) → correct_door_1 = 1, correct_door_2 = 2, seconds_left = 10.
- In SELECT, p1_right ×5 → player_1_pos = 3. Then p1_left and p1_right in the same cycle → stays 3. p2_left at pos 0 → stays 0.
- 10 ticks → time_up rises 1 cycle after the 10th tick. Buttons during REVEAL are ignored. time_up falls after 3 more ticks.
- Doors {1,2}, P1 at 3, P2 at 2 → after SCORE: p1_lives 3→2, p2_lives stays 3.
- START_LIVES = 1, both players on wrong doors → game_over = 1, winner = 11. Then start → lives = 1, new SELECT.
- Assert reset mid-REVEAL → all outputs return to reset values asynchronously, with time_up = 0 before the next edge.

Source files
------------

// File: rtl/door_game_pkg.sv
// Shared types, constants and helpers for the door game round sequencer.
package door_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REVEAL,
        ST_SCORE,
        ST_CHECK,
        ST_OVER
    } round_state_t;

    typedef logic [1:0] door_idx_t;

    localparam int unsigned LFSR_W  = 8;
    localparam int unsigned SEC_W   = 4;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned WIN_W   = 2;

    localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
    localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
    localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;
    localparam logic [WIN_W-1:0] WIN_TIE  = 2'b11;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    localparam door_idx_t POS_MAX = 2'd3;

    // Saturating player move; opposing pulses in the same cycle cancel.
    function automatic door_idx_t move_pos(door_idx_t pos, logic left, logic right);
        door_idx_t res;
        res = pos;
        if (left && !right && (pos != 2'd0)) begin
            res = pos - 2'd1;
        end else if (right && !left && (pos != POS_MAX)) begin
            res = pos + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used as the door randomiser.
module lfsr8
    import door_game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    // Shift left, feeding the tap parity into bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/door_round_controller.sv
// Round sequencer for the door game: door choice, countdown, moves, scoring.
module door_round_controller
    import door_game_pkg::*;
#(
    parameter int unsigned       ROUND_TICKS  = 10,
    parameter int unsigned       REVEAL_TICKS = 3,
    parameter int unsigned       START_LIVES  = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               p1_left,
    input  logic               p1_right,
    input  logic               p2_left,
    input  logic               p2_right,
    output logic [1:0]         correct_door_1,
    output logic [1:0]         correct_door_2,
    output logic [1:0]         player_1_pos,
    output logic [1:0]         player_2_pos,
    output logic [LIVES_W-1:0] p1_lives,
    output logic [LIVES_W-1:0] p2_lives,
    output logic               time_up,
    output logic [SEC_W-1:0]   seconds_left,
    output logic               game_over,
    output logic [WIN_W-1:0]   winner
);

    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);
    localparam logic [SEC_W-1:0]   SEC_INIT    = SEC_W'(ROUND_TICKS);
    localparam logic [SEC_W-1:0]   REVEAL_LAST = SEC_W'(REVEAL_TICKS - 1);

    round_state_t       state, state_nxt;
    logic [SEC_W-1:0]   reveal_cnt, reveal_cnt_nxt;
    door_idx_t          door_1_nxt, door_2_nxt;
    door_idx_t          pos_1_nxt, pos_2_nxt;
    logic [LIVES_W-1:0] lives_1_nxt, lives_2_nxt;
    logic               time_up_nxt;
    logic [SEC_W-1:0]   seconds_nxt;
    logic               game_over_nxt;
    logic [WIN_W-1:0]   winner_nxt;
    logic               new_round;

    logic [LFSR_W-1:0]  lfsr_q;
    logic               lfsr_unused;
    door_idx_t          pick_1, pick_2;
    logic               miss_1, miss_2;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    // Upper LFSR bits only feed the shift chain, never the door choice.
    assign lfsr_unused = ^lfsr_q[LFSR_W-1:4];

    // Door candidates; a clash on the second door bumps it to the next index.
    assign pick_1 = lfsr_q[1:0];
    assign pick_2 = (lfsr_q[3:2] == lfsr_q[1:0]) ? (lfsr_q[1:0] + 2'd1) : lfsr_q[3:2];

    assign miss_1 = (player_1_pos != correct_door_1) && (player_1_pos != correct_door_2);
    assign miss_2 = (player_2_pos != correct_door_1) && (player_2_pos != correct_door_2);

    // Next-state and next-output decode.
    always_comb begin
        state_nxt      = state;
        reveal_cnt_nxt = reveal_cnt;
        door_1_nxt     = correct_door_1;
        door_2_nxt     = correct_door_2;
        pos_1_nxt      = player_1_pos;
        pos_2_nxt      = player_2_pos;
        lives_1_nxt    = p1_lives;
        lives_2_nxt    = p2_lives;
        time_up_nxt    = time_up;
        seconds_nxt    = seconds_left;
        game_over_nxt  = game_over;
        winner_nxt     = winner;
        new_round      = 1'b0;

        case (state)
            ST_IDLE: begin
                lives_1_nxt = LIVES_INIT;
                lives_2_nxt = LIVES_INIT;
                if (start) begin
                    state_nxt = ST_SELECT;
                    new_round = 1'b1;
                end
            end
            ST_SELECT: begin
                pos_1_nxt = move_pos(player_1_pos, p1_left, p1_right);
                pos_2_nxt = move_pos(player_2_pos, p2_left, p2_right);
                if (tick) begin
                    seconds_nxt = seconds_left - SEC_W'(1);
                    if (seconds_left == SEC_W'(1)) begin
                        state_nxt      = ST_REVEAL;
                        time_up_nxt    = 1'b1;
                        reveal_cnt_nxt = '0;
                    end
                end
            end
            ST_REVEAL: begin
                if (tick) begin
                    if (reveal_cnt == REVEAL_LAST) begin
                        state_nxt      = ST_SCORE;
                        time_up_nxt    = 1'b0;
                        reveal_cnt_nxt = '0;
                    end else begin
                        reveal_cnt_nxt = reveal_cnt + SEC_W'(1);
                    end
                end
            end
            ST_SCORE: begin
                if (miss_1 && (p1_lives != '0)) begin
                    lives_1_nxt = p1_lives - LIVES_W'(1);
                end
                if (miss_2 && (p2_lives != '0)) begin
                    lives_2_nxt = p2_lives - LIVES_W'(1);
                end
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if ((p1_lives == '0) || (p2_lives == '0)) begin
                    state_nxt     = ST_OVER;
                    game_over_nxt = 1'b1;
                    if ((p1_lives == '0) && (p2_lives == '0)) begin
                        winner_nxt = WIN_TIE;
                    end else if (p1_lives == '0) begin
                        winner_nxt = WIN_P2;
                    end else begin
                        winner_nxt = WIN_P1;
                    end
                end else begin
                    state_nxt = ST_SELECT;
                    new_round = 1'b1;
                end
            end
            ST_OVER: begin
                if (start) begin
                    lives_1_nxt   = LIVES_INIT;
                    lives_2_nxt   = LIVES_INIT;
                    winner_nxt    = WIN_NONE;
                    game_over_nxt = 1'b0;
                    state_nxt     = ST_SELECT;
                    new_round     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (new_round) begin
            door_1_nxt  = pick_1;
            door_2_nxt  = pick_2;
            pos_1_nxt   = 2'd0;
            pos_2_nxt   = 2'd0;
            seconds_nxt = SEC_INIT;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            reveal_cnt     <= '0;
            correct_door_1 <= 2'd0;
            correct_door_2 <= 2'd1;
            player_1_pos   <= 2'd0;
            player_2_pos   <= 2'd0;
            p1_lives       <= LIVES_INIT;
            p2_lives       <= LIVES_INIT;
            time_up        <= 1'b0;
            seconds_left   <= '0;
            game_over      <= 1'b0;
            winner         <= WIN_NONE;
        end else begin
            state          <= state_nxt;
            reveal_cnt     <= reveal_cnt_nxt;
            correct_door_1 <= door_1_nxt;
            correct_door_2 <= door_2_nxt;
            player_1_pos   <= pos_1_nxt;
            player_2_pos   <= pos_2_nxt;
            p1_lives       <= lives_1_nxt;
            p2_lives       <= lives_2_nxt;
            time_up        <= time_up_nxt;
            seconds_left   <= seconds_nxt;
            game_over      <= game_over_nxt;
            winner         <= winner_nxt;
        end
    end

endmodule
